i2c_master_ctrl: RTL
====================

// Module: i2c_master_ctrl
// PURPOSE
//  Byte-level I2C master. Generates SCL and drives the open-drain SDA line for I2C_Slave.
//  Executes one command per handshake: START, WRITE, READ or STOP.
//  The host drives it command by command; no sequencing of its own.
//  Single master; no clock stretching; no arbitration.
// PARAMETERS
//  CLK_DIV  5  clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk); legal >= 2
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high when idle between commands; accept on cmd_valid & cmd_ready
//  cmd        in   2  00 START, 01 WRITE, 10 READ, 11 STOP
//  tx_data    in   8  byte to send on WRITE (MSB first), captured at accept
//  rd_nack    in   1  READ only: master ack bit (0 = ACK, 1 = NACK), captured at accept
//  rx_data    out  8  byte received by last READ; holds until next READ completes
//  rx_valid   out  1  1-clk pulse with done after a READ
//  ack_out    out  1  slave ack bit sampled on WRITE (0 = ACKed); holds until next WRITE
//  done       out  1  1-clk pulse when a command finishes
//  err        out  1  valid with done: command illegal in current bus state
//  busy       out  1  bus owned (after START until STOP finishes)
//  SCL        out  1  I2C clock (push-pull; the slave takes SCL as input only)
//  SDA        inout 1 open-drain: driven 0 or 1'bz, never driven 1
// BEHAVIOUR
//  Reset (async, rst_n=0): SCL=1, SDA=z, cmd_ready=1, busy=0. rx_data=0. All other outputs 0.
//   Reset mid-command aborts immediately and releases the bus.
//  Timebase: quarter tick every CLK_DIV clk. The counter runs only while a command executes.
//   It restarts at accept.
//  FSM: IDLE -> START | BIT | STOP -> IDLE. Every phase is exactly 4 quarters (q0..q3).
//  START (4q): q0 SDA=z, SCL unchanged (1 if !busy, 0 if busy); q1 SDA=z SCL=1;
//   q2 SDA=0 SCL=1; q3 SDA=0 SCL=0.
//   START while busy = repeated start; sets busy.
//  BIT (9 bits x 4q = 36q, WRITE or READ): q0,q1 SCL=0; q2,q3 SCL=1.
//   SDA is set at q0 entry and held to q3 end.
//   The receiver samples SDA on the last clk of q2.
//   WRITE: bits 0-7 drive tx_data[7-i] (1 -> z); bit 8 SDA=z, sample into ack_out.
//   READ: bits 0-7 SDA=z, shift samples into rx_data; bit 8 drive rd_nack (1 -> z).
//   SCL is left at 0 after bit 8.
//  STOP (4q): q0 SCL=0 SDA=0; q1 SCL=1 SDA=0; q2 SCL=1 SDA=z; q3 idle (SCL=1 SDA=z).
//   Clears busy at done.
//  Latency accept->done: START/STOP 4*CLK_DIV+1 clk; WRITE/READ 36*CLK_DIV+1 clk.
//   cmd_ready is low from accept through the done cycle and returns high the next clk.
//  Illegal: WRITE/READ/STOP with busy=0 -> no bus activity.
//   done and err pulse 1 clk after accept; ack_out and rx_data are unchanged.
//  cmd_valid while cmd_ready=0 is ignored; the host must hold it.
//   cmd and tx_data may change after accept.
//  rx_valid and err are 0 whenever done=0.
// STRUCTURE
//  i2c_defs.vh shared include: command encodings (CMD_START/WRITE/READ/STOP) and FSM state
//   constants. The same file also carries the quarter/bit count widths.
//  Sub-module i2c_qtick_gen: CLK_DIV counter. Outputs q_tick plus 2-bit quarter index;
//   has a synchronous clear.
//  Top holds the FSM, the 4-bit bit counter and the 8-bit shift register.
// TESTING (with I2C_Slave at address 7'h11, CLK_DIV=5, one clk per 2 ns)
//  1 Reset: rst_n low during the 4th WRITE bit -> same clk: SCL=1, SDA=z, cmd_ready=1, busy=0.
//  2 START, then WRITE 8'h22 -> ack_out=0; done at 21 and 181 clk after each accept;
//    SDA falls while SCL=1.
//  3 START, WRITE 8'h22, WRITE 8'h00, WRITE 8'h00..8'h77 (8 bytes), STOP
//    -> every ack_out=0; slave regs 0..7 hold 00,11,..,77.
//    SDA rises while SCL=1 at STOP; busy=0 after.
//  4 START, WRITE 8'h22, WRITE 8'h03, START (repeated), WRITE 8'h23, READ rd_nack=1, STOP
//    -> rx_data=8'h33, rx_valid one 1-clk pulse, SDA=z during master ack bit.
//  5 START, WRITE 8'h24 (address 7'h12) -> ack_out=1, err=0; then STOP completes normally.
//  6 From reset: WRITE, READ, STOP each -> done & err pulse at accept+1.
//    SCL and SDA never toggle; ack_out and rx_data unchanged.

Source files
------------

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared definitions for the byte-level I2C master.
// Holds the command encodings, the FSM state encoding and the widths of the
// quarter index and the bit counter. Imported by i2c_qtick_gen and i2c_master_ctrl.
package i2c_master_ctrl_pkg;

  // Host command encodings (cmd input)
  typedef enum logic [1:0] {
    CmdStart = 2'b00,
    CmdWrite = 2'b01,
    CmdRead  = 2'b10,
    CmdStop  = 2'b11
  } cmd_e;

  // Master FSM states; every non-idle phase is built from 4-quarter units
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StBit   = 2'b10,
    StStop  = 2'b11
  } state_e;

  localparam int unsigned QtrW    = 2;  // quarter index q0..q3
  localparam int unsigned BitCntW = 4;  // bit index 0..8 within a byte transfer

  localparam logic [BitCntW-1:0] LastDataBit = 4'd7;  // final data bit
  localparam logic [BitCntW-1:0] AckBit      = 4'd8;  // acknowledge bit

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase for the I2C master.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous restart of the divider and quarter index
//   en          count enable (high only while a command executes)
//   q_tick      high on the last clk of each quarter
//   quarter     index of the current quarter (0..3)
module i2c_qtick_gen
  import i2c_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic            q_tick,
  output logic [QtrW-1:0] quarter
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [QtrW-1:0] quarter_q;

  assign q_tick  = en && (cnt_q == CntMax);
  assign quarter = quarter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (clr) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else if (en) begin
      if (cnt_q == CntMax) begin
        cnt_q     <= '0;
        quarter_q <= quarter_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level single-master I2C controller. Executes one host command per
// handshake (START, WRITE, READ, STOP) and leaves sequencing to the host.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; cmd selects START/WRITE/READ/STOP
//   tx_data             byte sent by WRITE (MSB first), captured at accept
//   rd_nack             master ack bit for READ (1 = NACK), captured at accept
//   rx_data, rx_valid   byte of the last READ; rx_valid pulses with done
//   ack_out             slave ack bit of the last WRITE (0 = ACKed)
//   done, err           end-of-command pulse; err flags an illegal command
//   busy                bus owned between START and the end of STOP
//   SCL                 push-pull I2C clock
//   SDA                 open-drain data, only ever driven low
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       rd_nack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ack_out,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic       SCL,
  inout  wire        SDA
);

  state_e               state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [7:0]           shreg_q;
  logic                 is_read_q;
  logic                 rd_nack_q;
  logic                 scl_q;
  logic                 sda_oe_q;  // 1 = pull SDA low
  logic                 cmd_ready_q;
  logic                 done_q;
  logic                 err_q;
  logic                 rx_valid_q;
  logic                 ack_out_q;
  logic [7:0]           rx_data_q;
  logic                 busy_q;

  logic                 accept;
  logic                 legal;
  logic                 q_tick;
  logic [QtrW-1:0]      quarter;
  logic                 sda_in;
  cmd_e                 cmd_in;

  assign cmd_in = cmd_e'(cmd);
  assign accept = cmd_valid && cmd_ready_q;
  // Only START may open a transaction; everything else needs the bus.
  assign legal  = (cmd_in == CmdStart) || busy_q;
  assign sda_in = SDA;

  assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL       = scl_q;
  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rx_valid  = rx_valid_q;
  assign ack_out   = ack_out_q;
  assign rx_data   = rx_data_q;
  assign busy      = busy_q;

  i2c_qtick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (state_q != StIdle),
    .q_tick  (q_tick),
    .quarter (quarter)
  );

  // Outputs are set on entry to each quarter, i.e. on the q_tick ending the
  // previous quarter (or at accept for q0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      is_read_q   <= 1'b0;
      rd_nack_q   <= 1'b0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rx_valid_q  <= 1'b0;
      ack_out_q   <= 1'b0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      if (done_q) begin
        cmd_ready_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (!legal) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              unique case (cmd_in)
                CmdStart: begin
                  // SCL keeps its level: high on a fresh start, low on a repeated one
                  state_q  <= StStart;
                  sda_oe_q <= 1'b0;
                end
                CmdWrite: begin
                  state_q   <= StBit;
                  is_read_q <= 1'b0;
                  shreg_q   <= tx_data;
                  bit_cnt_q <= '0;
                  scl_q     <= 1'b0;
                  sda_oe_q  <= ~tx_data[7];
                end
                CmdRead: begin
                  state_q   <= StBit;
                  is_read_q <= 1'b1;
                  rd_nack_q <= rd_nack;
                  bit_cnt_q <= '0;
                  scl_q     <= 1'b0;
                  sda_oe_q  <= 1'b0;
                end
                CmdStop: begin
                  state_q  <= StStop;
                  scl_q    <= 1'b0;
                  sda_oe_q <= 1'b1;
                end
              endcase
            end
          end
        end

        StStart: begin
          if (q_tick) begin
            unique case (quarter)
              2'd0: scl_q    <= 1'b1;
              2'd1: sda_oe_q <= 1'b1;  // SDA falls while SCL is high
              2'd2: scl_q    <= 1'b0;
              2'd3: begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                busy_q  <= 1'b1;
              end
            endcase
          end
        end

        StBit: begin
          if (q_tick) begin
            unique case (quarter)
              2'd0: ;
              2'd1: scl_q <= 1'b1;
              2'd2: begin
                // Last clk of q2: the receiver's sample point
                if (is_read_q && (bit_cnt_q != AckBit)) begin
                  shreg_q <= {shreg_q[6:0], sda_in};
                end
                if (!is_read_q && (bit_cnt_q == AckBit)) begin
                  ack_out_q <= sda_in;
                end
              end
              2'd3: begin
                scl_q <= 1'b0;
                if (bit_cnt_q == AckBit) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  if (is_read_q) begin
                    rx_data_q  <= shreg_q;
                    rx_valid_q <= 1'b1;
                  end
                end else begin
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LastDataBit) begin
                    // Ack bit: WRITE releases for the slave, READ drives the host's ack
                    sda_oe_q <= is_read_q ? ~rd_nack_q : 1'b0;
                  end else if (is_read_q) begin
                    sda_oe_q <= 1'b0;
                  end else begin
                    sda_oe_q <= ~shreg_q[6];
                    shreg_q  <= {shreg_q[6:0], 1'b0};
                  end
                end
              end
            endcase
          end
        end

        StStop: begin
          if (q_tick) begin
            unique case (quarter)
              2'd0: scl_q    <= 1'b1;
              2'd1: sda_oe_q <= 1'b0;  // SDA rises while SCL is high
              2'd2: ;
              2'd3: begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
